alu_issue_arbiter: RTL

Shares the single execute-stage ALU and its operation decode between two requesters: port 0 is the core execute path and port 1 is the branch/address helper. Each request carries an opcode, funct3, funct7 and two operands. The block arbitrates round-robin, sequences one operation at a time through the shared decode and ALU, registers the result, and returns it with the requester ID on a single valid/ready response channel. Decode errors are reported per transaction and counted.

---
 rtl/alu_issue_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one decode/ALU between two requesters, one
// operation at a time, with a registered valid/ready response channel.
module alu_issue_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [6:0]          req0_opcode,
   input  logic [2:0]          req0_funct3,
   input  logic [6:0]          req0_funct7,
   input  logic [WIDTH-1:0]    req0_a,
   input  logic [WIDTH-1:0]    req0_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [6:0]          req1_opcode,
   input  logic [2:0]          req1_funct3,
   input  logic [6:0]          req1_funct7,
   input  logic [WIDTH-1:0]    req1_a,
   input  logic [WIDTH-1:0]    req1_b,
   output logic [6:0]          dec_opcode,
   output logic [2:0]          dec_alu_op,
   output logic [6:0]          dec_func7,
   input  logic                dec_err,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic                alu_cond,
   input  logic                flush,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [WIDTH-1:0]    rsp_result,
   output logic                rsp_cond,
   output logic                rsp_err,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             last_grant;
   logic             grant_id;
   logic             can_accept;
   logic [6:0]       lat_opcode;
   logic [2:0]       lat_funct3;
   logic [6:0]       lat_funct7;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic             lat_id;

   // With both ports valid the port that did not win last time gets the slot.
   always_comb begin
      grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      can_accept = (state == IDLE) && !flush && !rst;
      req0_ready = can_accept && req0_valid && !grant_id;
      req1_ready = can_accept && req1_valid && grant_id;
   end

   always_comb begin
      dec_opcode = '0;
      dec_alu_op = '0;
      dec_func7  = '0;
      if (state == EXEC) begin
         dec_opcode = lat_opcode;
         dec_alu_op = lat_funct3;
         dec_func7  = lat_funct7;
      end
      alu_a = lat_a;
      alu_b = lat_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         err_count  <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_cond   <= 1'b0;
         rsp_err    <= 1'b0;
         lat_opcode <= '0;
         lat_funct3 <= '0;
         lat_funct7 <= '0;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  lat_opcode <= req1_ready ? req1_opcode : req0_opcode;
                  lat_funct3 <= req1_ready ? req1_funct3 : req0_funct3;
                  lat_funct7 <= req1_ready ? req1_funct7 : req0_funct7;
                  lat_a      <= req1_ready ? req1_a : req0_a;
                  lat_b      <= req1_ready ? req1_b : req0_b;
                  lat_id     <= req1_ready;
                  last_grant <= req1_ready;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= lat_id;
                  rsp_err    <= dec_err;
                  rsp_result <= dec_err ? '0 : alu_result;
                  rsp_cond   <= dec_err ? 1'b0 : alu_cond;
                  if (dec_err && (err_count != '1))
                     err_count <= err_count + ERRCNT_W'(1);
                  state <= RESP;
               end
            end
            RESP: begin
               // A handshake and a flush land in the same place.
               if (rsp_ready || flush) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
